lfsr_bit_stats: RTL and testbench



---
 rtl/lfsr_pkg.sv | 37 +++
 rtl/lfsr_bit_stats_run_tracker.sv | 74 +++++++
 rtl/lfsr_bit_stats.sv | 146 ++++++++++++++
 tb/tb_lfsr_bit_stats.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR bit-statistics block: default widths, stats record, saturating increment.
// Stats fields are sized for the widest supported build; narrower builds keep the upper bits at constant zero.
package lfsr_pkg;

    localparam int CNT_W_DEF = 14;
    localparam int RUN_W_DEF = 6;
    localparam int CNT_MAX_W = 32;
    localparam int RUN_MAX_W = 16;

    typedef logic [CNT_MAX_W-1:0] cnt_t;
    typedef logic [RUN_MAX_W-1:0] run_t;

    typedef struct packed {
        cnt_t ones;
        cnt_t zeros;
        run_t run1;
        run_t run0;
        logic sat;
    } stats_t;

    function automatic cnt_t width_mask(input int unsigned w);
        return (w >= CNT_MAX_W) ? '1 : ((cnt_t'(1) << w) - cnt_t'(1));
    endfunction

    // True when a further increment of a w-bit counter would be lost.
    function automatic logic sat_hit(input cnt_t v, input int unsigned w);
        return (v & width_mask(w)) == width_mask(w);
    endfunction

    // Masking with a constant lets synthesis drop the unused upper bits.
    function automatic cnt_t sat_inc(input cnt_t v, input int unsigned w);
        cnt_t mask;
        mask = width_mask(w);
        return sat_hit(v, w) ? mask : ((v + cnt_t'(1)) & mask);
    endfunction

endpackage

// File: rtl/lfsr_bit_stats_run_tracker.sv
// Tracks the current run of equal sampled bits and the longest run of each polarity.
// Latency: a sample is reflected after the edge that takes it; backpressure: none, i_sample is a strobe.
module run_tracker
    import lfsr_pkg::*;
#(
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_sample,
    input  logic             i_bit,
    input  logic             i_clr,
    output logic [RUN_W-1:0] o_max_run1,
    output logic [RUN_W-1:0] o_max_run0,
    output logic             o_sat
);

    logic             r_empty;
    logic             r_cur_val;
    logic             r_sat;
    logic [RUN_W-1:0] r_cur_run;
    logic [RUN_W-1:0] r_max_run1;
    logic [RUN_W-1:0] r_max_run0;

    logic             w_run_start;
    logic             w_run_sat;
    logic [RUN_W-1:0] w_next_run;
    logic [RUN_W-1:0] w_longest;

    always_comb begin
        w_run_start = r_empty || (i_bit != r_cur_val);
        w_run_sat   = !w_run_start && sat_hit(cnt_t'(r_cur_run), RUN_W);
        w_next_run  = w_run_start ? RUN_W'(1) : RUN_W'(sat_inc(cnt_t'(r_cur_run), RUN_W));
        w_longest   = i_bit ? r_max_run1 : r_max_run0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_empty    <= 1'b1;
            r_cur_val  <= 1'b0;
            r_cur_run  <= '0;
            r_max_run1 <= '0;
            r_max_run0 <= '0;
            r_sat      <= 1'b0;
        end else if (i_clr) begin
            r_empty    <= 1'b1;
            r_cur_val  <= 1'b0;
            r_cur_run  <= '0;
            r_max_run1 <= '0;
            r_max_run0 <= '0;
            r_sat      <= 1'b0;
        end else if (i_sample) begin
            r_empty   <= 1'b0;
            r_cur_val <= i_bit;
            r_cur_run <= w_next_run;
            // Longest run is updated on the same edge so the bit is fully accounted for.
            if (w_next_run > w_longest) begin
                if (i_bit) begin
                    r_max_run1 <= w_next_run;
                end else begin
                    r_max_run0 <= w_next_run;
                end
            end
            if (w_run_sat) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign o_max_run1 = r_max_run1;
    assign o_max_run0 = r_max_run0;
    assign o_sat      = r_sat;

endmodule

// File: rtl/lfsr_bit_stats.sv
// Per-LFSR-period bit statistics (ones, zeros, longest runs, saturation) snapshotted on max_tick; LFSR_BIT_STATS_TRANSITION_EN adds trans_cnt.
// Latency: snapshot outputs and the stats_valid pulse appear one edge after max_tick; backpressure: none.
module lfsr_bit_stats
    import lfsr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             max_tick,
    input  logic             clr,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] zeros_cnt,
    output logic [RUN_W-1:0] max_run1,
    output logic [RUN_W-1:0] max_run0,
    output logic             sat,
    output logic             stats_valid
`ifdef LFSR_BIT_STATS_TRANSITION_EN
    ,
    output logic [CNT_W-1:0] trans_cnt
`endif
);

    stats_t           r_live;
    stats_t           r_snap;
    stats_t           w_live;
    logic             r_stats_vld;

    logic             w_clear;
    logic             w_sample;
    logic             w_run_sat;
    logic             w_extra_sat;
    logic [RUN_W-1:0] w_max_run1;
    logic [RUN_W-1:0] w_max_run0;

    // max_tick wins over clr; the seed bit presented with max_tick is never counted.
    assign w_clear  = max_tick | clr;
    assign w_sample = bit_valid & ~w_clear;

    run_tracker #(
        .RUN_W(RUN_W)
    ) u_run (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_sample  (w_sample),
        .i_bit     (bit_in),
        .i_clr     (w_clear),
        .o_max_run1(w_max_run1),
        .o_max_run0(w_max_run0),
        .o_sat     (w_run_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= '0;
        end else if (w_clear) begin
            r_live <= '0;
        end else if (w_sample) begin
            if (bit_in) begin
                r_live.ones <= sat_inc(r_live.ones, CNT_W);
                if (sat_hit(r_live.ones, CNT_W)) begin
                    r_live.sat <= 1'b1;
                end
            end else begin
                r_live.zeros <= sat_inc(r_live.zeros, CNT_W);
                if (sat_hit(r_live.zeros, CNT_W)) begin
                    r_live.sat <= 1'b1;
                end
            end
        end
    end

`ifdef LFSR_BIT_STATS_TRANSITION_EN
    logic r_prev_bit;
    logic r_prev_vld;
    logic r_trans_sat;
    cnt_t r_trans;
    cnt_t r_trans_snap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_bit  <= 1'b0;
            r_prev_vld  <= 1'b0;
            r_trans     <= '0;
            r_trans_sat <= 1'b0;
        end else if (w_clear) begin
            r_prev_bit  <= 1'b0;
            r_prev_vld  <= 1'b0;
            r_trans     <= '0;
            r_trans_sat <= 1'b0;
        end else if (w_sample) begin
            r_prev_bit <= bit_in;
            r_prev_vld <= 1'b1;
            if (r_prev_vld && (bit_in != r_prev_bit)) begin
                r_trans <= sat_inc(r_trans, CNT_W);
                if (sat_hit(r_trans, CNT_W)) begin
                    r_trans_sat <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trans_snap <= '0;
        end else if (max_tick) begin
            r_trans_snap <= r_trans;
        end
    end

    assign w_extra_sat = r_trans_sat;
    assign trans_cnt   = CNT_W'(r_trans_snap);
`else
    assign w_extra_sat = 1'b0;
`endif

    always_comb begin
        w_live      = r_live;
        w_live.run1 = run_t'(w_max_run1);
        w_live.run0 = run_t'(w_max_run0);
        w_live.sat  = r_live.sat | w_run_sat | w_extra_sat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap      <= '0;
            r_stats_vld <= 1'b0;
        end else begin
            r_stats_vld <= max_tick;
            if (max_tick) begin
                r_snap <= w_live;
            end
        end
    end

    assign ones_cnt    = CNT_W'(r_snap.ones);
    assign zeros_cnt   = CNT_W'(r_snap.zeros);
    assign max_run1    = RUN_W'(r_snap.run1);
    assign max_run0    = RUN_W'(r_snap.run0);
    assign sat         = r_snap.sat;
    assign stats_valid = r_stats_vld;

endmodule

// File: tb/tb_lfsr_bit_stats.sv
// Directed bench for lfsr_bit_stats: default build plus a narrow CNT_W=4/RUN_W=3 build for saturation.
module tb_lfsr_bit_stats;

    logic clk = 1'b0;
    logic reset_n;
    logic bit_in;
    logic bit_valid;
    logic max_tick;
    logic clr;

    logic [13:0] ones_cnt, zeros_cnt, trans_cnt;
    logic [5:0]  max_run1, max_run0;
    logic        sat, stats_valid;

    logic [3:0]  s_ones, s_zeros, s_trans;
    logic [2:0]  s_run1, s_run0;
    logic        s_sat, s_vld;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_bit_stats u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .max_tick   (max_tick),
        .clr        (clr),
        .ones_cnt   (ones_cnt),
        .zeros_cnt  (zeros_cnt),
        .max_run1   (max_run1),
        .max_run0   (max_run0),
        .sat        (sat),
        .stats_valid(stats_valid)
`ifdef LFSR_BIT_STATS_TRANSITION_EN
        ,
        .trans_cnt  (trans_cnt)
`endif
    );

    lfsr_bit_stats #(
        .CNT_W(4),
        .RUN_W(3)
    ) u_sat (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .max_tick   (max_tick),
        .clr        (clr),
        .ones_cnt   (s_ones),
        .zeros_cnt  (s_zeros),
        .max_run1   (s_run1),
        .max_run0   (s_run0),
        .sat        (s_sat),
        .stats_valid(s_vld)
`ifdef LFSR_BIT_STATS_TRANSITION_EN
        ,
        .trans_cnt  (s_trans)
`endif
    );

`ifndef LFSR_BIT_STATS_TRANSITION_EN
    assign trans_cnt = '0;
    assign s_trans   = '0;
`endif

    task automatic send(input logic b);
        @(negedge clk);
        bit_in = b; bit_valid = 1'b1; max_tick = 1'b0; clr = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        bit_valid = 1'b0; max_tick = 1'b0; clr = 1'b0;
    endtask

    // Drives max_tick for one edge and returns #1 after that edge.
    task automatic tick(input logic seed_vld, input logic seed_bit, input logic with_clr);
        @(negedge clk);
        max_tick = 1'b1; bit_valid = seed_vld; bit_in = seed_bit; clr = with_clr;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; max_tick = 1'b0; clr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (ones_cnt !== 14'd0 || zeros_cnt !== 14'd0) begin n_fail++; $display("FAIL reset_cnts got %0d/%0d want 0/0", ones_cnt, zeros_cnt); end
        n_tests++; if (max_run1 !== 6'd0 || max_run0 !== 6'd0 || sat !== 1'b0) begin n_fail++; $display("FAIL reset_runs got %0d/%0d/%0b want 0/0/0", max_run1, max_run0, sat); end
        n_tests++; if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %0b want 0", stats_valid); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rel_vld got %0b want 0", stats_valid); end
    endtask

    task automatic test_pattern();
        send(1); send(1); send(1); send(0); send(0); send(1);
        tick(0, 0, 0);
        n_tests++; if (ones_cnt !== 14'd4) begin n_fail++; $display("FAIL pat_ones got %0d want 4", ones_cnt); end
        n_tests++; if (zeros_cnt !== 14'd2) begin n_fail++; $display("FAIL pat_zeros got %0d want 2", zeros_cnt); end
        n_tests++; if (max_run1 !== 6'd3) begin n_fail++; $display("FAIL pat_run1 got %0d want 3", max_run1); end
        n_tests++; if (max_run0 !== 6'd2) begin n_fail++; $display("FAIL pat_run0 got %0d want 2", max_run0); end
        n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL pat_sat got %0b want 0", sat); end
        n_tests++; if (stats_valid !== 1'b1) begin n_fail++; $display("FAIL pat_vld got %0b want 1", stats_valid); end
`ifdef LFSR_BIT_STATS_TRANSITION_EN
        n_tests++; if (trans_cnt !== 14'd2) begin n_fail++; $display("FAIL pat_trans got %0d want 2", trans_cnt); end
`endif
        gap();
        @(posedge clk); #1;
        n_tests++; if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL pat_vld_drop got %0b want 0", stats_valid); end
        n_tests++; if (ones_cnt !== 14'd4 || max_run1 !== 6'd3) begin n_fail++; $display("FAIL pat_hold got %0d/%0d want 4/3", ones_cnt, max_run1); end
    endtask

    task automatic test_reset_activity();
        send(1); send(0); send(1); send(1); send(0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (ones_cnt !== 14'd0 || zeros_cnt !== 14'd0) begin n_fail++; $display("FAIL rst_mid_cnts got %0d/%0d want 0/0", ones_cnt, zeros_cnt); end
        n_tests++; if (max_run1 !== 6'd0 || s_ones !== 4'd0) begin n_fail++; $display("FAIL rst_mid_runs got %0d/%0d want 0/0", max_run1, s_ones); end
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_tests++; if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_vld cycle %0d got %0b want 0", i, stats_valid); end
        end
        tick(0, 0, 0);
        n_tests++; if (ones_cnt !== 14'd0 || zeros_cnt !== 14'd0 || max_run1 !== 6'd0 || stats_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_snap got ones=%0d zeros=%0d run1=%0d vld=%0b want 0/0/0/1", ones_cnt, zeros_cnt, max_run1, stats_valid);
        end
    endtask

    task automatic test_gaps();
        send(1); gap(); send(1); gap(); gap(); send(1); gap();
        send(0); gap(); send(0); send(1); gap();
        tick(1, 1, 0);
        n_tests++; if (ones_cnt !== 14'd4 || zeros_cnt !== 14'd2) begin n_fail++; $display("FAIL gap_cnts got %0d/%0d want 4/2", ones_cnt, zeros_cnt); end
        n_tests++; if (max_run1 !== 6'd3 || max_run0 !== 6'd2) begin n_fail++; $display("FAIL gap_runs got %0d/%0d want 3/2", max_run1, max_run0); end
        n_tests++; if (sat !== 1'b0 || stats_valid !== 1'b1) begin n_fail++; $display("FAIL gap_flags got sat=%0b vld=%0b want 0/1", sat, stats_valid); end
    endtask

    task automatic test_clr();
        send(1); send(1); send(1);
        @(negedge clk);
        clr = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; max_tick = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (stats_valid !== 1'b0 || ones_cnt !== 14'd4) begin n_fail++; $display("FAIL clr_out_hold got vld=%0b ones=%0d want 0/4", stats_valid, ones_cnt); end
        send(0); send(0);
        tick(0, 0, 0);
        n_tests++; if (ones_cnt !== 14'd0 || zeros_cnt !== 14'd2) begin n_fail++; $display("FAIL clr_cnts got %0d/%0d want 0/2", ones_cnt, zeros_cnt); end
        n_tests++; if (max_run1 !== 6'd0 || max_run0 !== 6'd2) begin n_fail++; $display("FAIL clr_runs got %0d/%0d want 0/2", max_run1, max_run0); end
        send(1); send(1);
        tick(0, 0, 1);
        n_tests++; if (ones_cnt !== 14'd2 || max_run1 !== 6'd2 || stats_valid !== 1'b1) begin
            n_fail++; $display("FAIL clr_tick_snap got ones=%0d run1=%0d vld=%0b want 2/2/1", ones_cnt, max_run1, stats_valid);
        end
        send(0);
        tick(0, 0, 0);
        n_tests++; if (ones_cnt !== 14'd0 || zeros_cnt !== 14'd1 || max_run0 !== 6'd1) begin
            n_fail++; $display("FAIL clr_tick_next got ones=%0d zeros=%0d run0=%0d want 0/1/1", ones_cnt, zeros_cnt, max_run0);
        end
    endtask

    task automatic test_back_to_back();
        send(0); send(0); send(0);
        tick(0, 0, 0);
        n_tests++; if (zeros_cnt !== 14'd3 || max_run0 !== 6'd3 || ones_cnt !== 14'd0) begin n_fail++; $display("FAIL b2b_first got zeros=%0d run0=%0d ones=%0d want 3/3/0", zeros_cnt, max_run0, ones_cnt); end
        tick(0, 0, 0);
        n_tests++; if (zeros_cnt !== 14'd0 || max_run0 !== 6'd0 || sat !== 1'b0) begin n_fail++; $display("FAIL b2b_second got zeros=%0d run0=%0d sat=%0b want 0/0/0", zeros_cnt, max_run0, sat); end
        n_tests++; if (stats_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_vld got %0b want 1", stats_valid); end
        gap();
        @(posedge clk); #1;
        n_tests++; if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_vld_drop got %0b want 0", stats_valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 11; i++) send(1);
        tick(0, 0, 0);
        n_tests++; if (s_ones !== 4'd11 || s_run1 !== 3'd7 || s_sat !== 1'b1) begin n_fail++; $display("FAIL sat_run got ones=%0d run1=%0d sat=%0b want 11/7/1", s_ones, s_run1, s_sat); end
        n_tests++; if (ones_cnt !== 14'd11 || max_run1 !== 6'd11 || sat !== 1'b0) begin n_fail++; $display("FAIL sat_wide got ones=%0d run1=%0d sat=%0b want 11/11/0", ones_cnt, max_run1, sat); end
        for (int i = 0; i < 17; i++) send(1);
        tick(0, 0, 0);
        n_tests++; if (s_ones !== 4'd15 || s_zeros !== 4'd0 || s_sat !== 1'b1) begin n_fail++; $display("FAIL sat_cnt got ones=%0d zeros=%0d sat=%0b want 15/0/1", s_ones, s_zeros, s_sat); end
        n_tests++; if (ones_cnt !== 14'd17 || max_run1 !== 6'd17) begin n_fail++; $display("FAIL sat_cnt_wide got ones=%0d run1=%0d want 17/17", ones_cnt, max_run1); end
        send(1); send(0);
        tick(0, 0, 0);
        n_tests++; if (s_sat !== 1'b0 || s_ones !== 4'd1 || s_zeros !== 4'd1 || s_vld !== 1'b1) begin
            n_fail++; $display("FAIL sat_clear got sat=%0b ones=%0d zeros=%0d vld=%0b want 0/1/1/1", s_sat, s_ones, s_zeros, s_vld);
        end
    endtask

    task automatic test_trans();
        send(1); send(0); send(1); send(1); send(0);
        tick(0, 0, 0);
        n_tests++; if (ones_cnt !== 14'd3 || zeros_cnt !== 14'd2) begin n_fail++; $display("FAIL trn_cnts got %0d/%0d want 3/2", ones_cnt, zeros_cnt); end
        n_tests++; if (max_run1 !== 6'd2 || max_run0 !== 6'd1) begin n_fail++; $display("FAIL trn_runs got %0d/%0d want 2/1", max_run1, max_run0); end
`ifdef LFSR_BIT_STATS_TRANSITION_EN
        n_tests++; if (trans_cnt !== 14'd3 || s_trans !== 4'd3) begin n_fail++; $display("FAIL trn_cnt got %0d/%0d want 3/3", trans_cnt, s_trans); end
`endif
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_reset_activity();
        test_gaps();
        test_clr();
        test_back_to_back();
        test_saturation();
        test_trans();
        gap();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
